mac_unit_pragmatic_seq: RTL and testbench

//   Parametrised, self-sequencing Pragmatic (essential-bit serial) dot-product MAC.
//   - Accepts one group of VEC_LENGTH signed activation/weight pairs per valid/ready handshake.
//   - Internally decomposes each |weight| into its set bits, one term per lane per cycle.
//   - Group time is therefore the maximum weight popcount, not DATA_WIDTH.
//   - Accumulates across groups and emits the dot product on an output valid/ready handshake.
//   - Sits between the weight/activation buffers and the output writeback of a PE column.

---
 rtl/mac_unit_pragmatic_seq_if.sv | 35 +++
 rtl/mac_unit_pragmatic_seq.sv | 151 +++++++++++++++
 tb/tb_mac_unit_pragmatic_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_unit_pragmatic_seq_if.sv
// Group-input and result handshake bundle for the Pragmatic bit-serial MAC.
// The master side supplies groups and takes results; the slave side is the MAC.
interface mac_unit_pragmatic_seq_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
);
    // Group input channel
    logic                                 grp_valid;
    logic                                 grp_ready;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] wgt_in;
    logic                                 grp_first;
    logic                                 grp_last;
    logic                                 load_accum;
    logic [ACC_WIDTH-1:0]                 accum_prev;

    // Result channel and status
    logic                                 out_valid;
    logic                                 out_ready;
    logic [ACC_WIDTH-1:0]                 accum_out;
    logic [RESULT_WIDTH-1:0]              result;
    logic                                 busy;

    modport master (
        output grp_valid, act_in, wgt_in, grp_first, grp_last, load_accum, accum_prev, out_ready,
        input  grp_ready, out_valid, accum_out, result, busy
    );

    modport slave (
        input  grp_valid, act_in, wgt_in, grp_first, grp_last, load_accum, accum_prev, out_ready,
        output grp_ready, out_valid, accum_out, result, busy
    );
endinterface

// File: rtl/mac_unit_pragmatic_seq.sv
// Pragmatic (essential-bit serial) dot-product MAC.
// Each weight magnitude is consumed one set bit per cycle per lane, so a group
// takes as many RUN cycles as its largest weight popcount (minimum one).
// Lane terms are summed by a full adder tree into a psum register, which is
// folded into the accumulator one cycle later.
module mac_unit_pragmatic_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic clk,
    input  logic reset,
    mac_unit_pragmatic_seq_if.slave bus
);
    localparam int LOG2   = $clog2(VEC_LENGTH);
    localparam int TW     = 2 * DATA_WIDTH;          // lane term width
    localparam int PW     = TW + LOG2;               // adder tree output width
    localparam int PIDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRAP, S_OUT} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_act;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_res;
    logic [VEC_LENGTH-1:0]                 r_sign;
    logic                                  r_last;
    logic signed [PW-1:0]                  r_psum;
    logic                                  r_psum_vld;
    logic [ACC_WIDTH-1:0]                  r_acc;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_abs;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_res_clr;
    logic signed [TW-1:0]                  w_term [VEC_LENGTH];
    logic signed [PW-1:0]                  w_psum;
    logic                                  w_accept;
    logic                                  w_run_done;

    assign w_accept   = (r_state == S_IDLE) && bus.grp_valid && !reset;
    assign w_run_done = (w_res_clr == '0);

    // Per-lane magnitude capture and one-bit-per-cycle term generation
    for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
        logic [PIDX_W-1:0]      w_pos;
        logic signed [DATA_WIDTH:0] w_act_ext;
        logic signed [DATA_WIDTH:0] w_act_sgn;

        // |w| as unsigned: the most negative weight maps to 2^(DW-1), which still fits
        assign w_abs[gi] = bus.wgt_in[gi][DATA_WIDTH-1]
                         ? (~bus.wgt_in[gi] + DATA_WIDTH'(1))
                         : bus.wgt_in[gi];

        // Lowest set bit of the residue picks this cycle's shift
        always_comb begin
            w_pos = '0;
            for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
                if (r_res[gi][b]) begin
                    w_pos = PIDX_W'(b);
                end
            end
        end

        // One extra bit so negating the most negative activation stays exact
        assign w_act_ext = {r_act[gi][DATA_WIDTH-1], r_act[gi]};
        assign w_act_sgn = r_sign[gi] ? -w_act_ext : w_act_ext;

        assign w_term[gi]    = (r_res[gi] == '0) ? '0 : (TW'(w_act_sgn) <<< w_pos);
        assign w_res_clr[gi] = r_res[gi] & (r_res[gi] - DATA_WIDTH'(1));
    end

    // Full adder tree, one bit of growth per level
    for (genvar gi = 0; gi < LOG2; gi++) begin : g_lvl
        localparam int N = VEC_LENGTH >> (gi + 1);
        localparam int W = TW + gi + 1;
        logic signed [W-1:0] sum [N];
        for (genvar gj = 0; gj < N; gj++) begin : g_node
            if (gi == 0) begin : g_leaf
                assign sum[gj] = W'(w_term[2*gj]) + W'(w_term[2*gj+1]);
            end else begin : g_inner
                assign sum[gj] = W'(g_lvl[gi-1].sum[2*gj]) + W'(g_lvl[gi-1].sum[2*gj+1]);
            end
        end
    end

    assign w_psum = g_lvl[LOG2-1].sum[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_RUN;
            S_RUN:   if (w_run_done)    w_state_next = S_WRAP;
            S_WRAP:  w_state_next = r_last ? S_OUT : S_IDLE;
            S_OUT:   if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: group capture, residue clearing, psum pipeline and accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act      <= '0;
            r_res      <= '0;
            r_sign     <= '0;
            r_last     <= 1'b0;
            r_psum     <= '0;
            r_psum_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_psum_vld <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_psum <= w_psum;
            end

            if (w_accept) begin
                r_act  <= bus.act_in;
                r_res  <= w_abs;
                r_last <= bus.grp_last;
                for (int i = 0; i < VEC_LENGTH; i++) begin
                    r_sign[i] <= bus.wgt_in[i][DATA_WIDTH-1];
                end
            end else if (r_state == S_RUN) begin
                r_res <= w_res_clr;
            end

            // Seeding only happens in IDLE, where no psum is ever pending
            if (w_accept && bus.grp_first) begin
                r_acc <= bus.load_accum ? bus.accum_prev : '0;
            end else if (r_psum_vld) begin
                r_acc <= r_acc + ACC_WIDTH'(r_psum);
            end
        end
    end

    assign bus.grp_ready = (r_state == S_IDLE) && !reset;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.accum_out = r_acc;
    assign bus.result    = r_acc[ACC_WIDTH-1 -: RESULT_WIDTH];
endmodule

// File: tb/tb_mac_unit_pragmatic_seq.sv
// Directed bench for the Pragmatic bit-serial MAC: latency, dot-product values,
// multi-group accumulation, output back-pressure and mid-group reset.
module tb_mac_unit_pragmatic_seq;
    localparam int DW = 8;
    localparam int VL = 16;
    localparam int AW = DW + 16;
    localparam int RW = 2 * DW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mac_unit_pragmatic_seq_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .RESULT_WIDTH(RW)) bus ();

    mac_unit_pragmatic_seq #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .RESULT_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] w);
        for (int i = 0; i < VL; i++) begin
            bus.act_in[i] = a;
            bus.wgt_in[i] = w;
        end
    endtask

    // Offer one group in IDLE, then wait for out_valid or return to IDLE.
    // lat is the cycle index (accept cycle = 0) where that happened, -1 on timeout.
    task automatic do_group(input string tag, input logic first, input logic last, input logic load,
                            input logic [AW-1:0] prev, output int lat, output bit saw);
        bit done;
        bus.grp_first  = first;
        bus.grp_last   = last;
        bus.load_accum = load;
        bus.accum_prev = prev;
        bus.grp_valid  = 1'b1;
        chk({tag, " grp_ready at accept"}, bus.grp_ready, 1);
        tick();
        bus.grp_valid = 1'b0;
        lat  = -1;
        saw  = 1'b0;
        done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (!done) begin
                if (bus.out_valid) begin
                    lat = c; saw = 1'b1; done = 1'b1;
                end else if (!bus.busy) begin
                    lat = c; done = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        $display("group %s: first=%0b last=%0b load=%0b lat=%0d out_valid=%0b accum_out=%0d",
                 tag, first, last, load, lat, saw, $signed(bus.accum_out));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  saw;
        logic [RW-1:0] held;

        reset          = 1'b1;
        bus.grp_valid  = 1'b0;
        bus.grp_first  = 1'b0;
        bus.grp_last   = 1'b0;
        bus.load_accum = 1'b0;
        bus.accum_prev = '0;
        bus.out_ready  = 1'b1;
        set_all('0, '0);

        // Reset state
        repeat (3) tick();
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset grp_ready", bus.grp_ready, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset accum_out", $signed(bus.accum_out), 0);
        reset = 1'b0;
        tick();
        chk("idle grp_ready", bus.grp_ready, 1);

        // 1: all lanes 3*5, k=2
        set_all(8'd3, 8'd5);
        do_group("t1", 1, 1, 0, '0, lat, saw);
        chk("t1 latency", lat, 4);
        chk("t1 accum_out", $signed(bus.accum_out), 240);
        chk("t1 result", $signed(bus.result), 0);
        tick();
        chk("t1 back to idle", bus.busy, 0);

        // 2a: -128 * -128 on lane 0, k=1
        set_all('0, '0);
        bus.act_in[0] = 8'h80;
        bus.wgt_in[0] = 8'h80;
        do_group("t2a", 1, 1, 0, '0, lat, saw);
        chk("t2a latency", lat, 3);
        chk("t2a accum_out", $signed(bus.accum_out), 16384);
        chk("t2a result", $signed(bus.result), 64);
        tick();

        // 2b: -128 * 127 on lane 0, k=7
        bus.wgt_in[0] = 8'd127;
        do_group("t2b", 1, 1, 0, '0, lat, saw);
        chk("t2b latency", lat, 9);
        chk("t2b accum_out", $signed(bus.accum_out), -16256);
        tick();

        // 3: seeded two-group dot product
        set_all(8'd1, 8'd1);
        do_group("t3a", 1, 0, 1, AW'(1000), lat, saw);
        chk("t3a no out_valid", saw, 0);
        chk("t3a idle latency", lat, 3);
        chk("t3a partial accum", $signed(bus.accum_out), 1016);
        set_all(8'd2, 8'hFD);
        do_group("t3b", 0, 1, 0, '0, lat, saw);
        chk("t3b out_valid", saw, 1);
        chk("t3b latency", lat, 4);
        chk("t3b accum_out", $signed(bus.accum_out), 920);
        tick();

        // 4: all-zero weights, seed -7
        set_all(8'd9, 8'd0);
        do_group("t4", 1, 1, 1, AW'(-7), lat, saw);
        chk("t4 latency", lat, 3);
        chk("t4 accum_out", $signed(bus.accum_out), -7);
        chk("t4 result", $signed(bus.result), -1);
        tick();

        // 5: back-pressure in OUT
        bus.out_ready = 1'b0;
        set_all(8'd3, 8'd5);
        do_group("t5", 1, 1, 0, '0, lat, saw);
        chk("t5 latency", lat, 4);
        held = bus.result;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t5 out_valid held", bus.out_valid, 1);
            chk("t5 result stable", bus.result, held);
            chk("t5 accum_out held", $signed(bus.accum_out), 240);
            chk("t5 grp_ready low", bus.grp_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("t5 idle after accept", bus.busy, 0);
        chk("t5 out_valid cleared", bus.out_valid, 0);
        chk("t5 grp_ready back", bus.grp_ready, 1);

        // 6: reset during the second RUN cycle of a k=4 group
        set_all(8'd1, 8'd15);
        bus.grp_first = 1'b1;
        bus.grp_last  = 1'b1;
        bus.load_accum = 1'b0;
        bus.grp_valid = 1'b1;
        tick();
        bus.grp_valid = 1'b0;
        tick();
        chk("t6 busy in run", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 busy after reset", bus.busy, 0);
        chk("t6 accum after reset", $signed(bus.accum_out), 0);
        saw = bus.out_valid;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.out_valid) saw = 1'b1;
        end
        $display("group t6: aborted by reset, out_valid seen=%0b", saw);
        chk("t6 no out_valid", saw, 0);
        set_all(8'd3, 8'd5);
        do_group("t6b", 1, 1, 0, '0, lat, saw);
        chk("t6b latency", lat, 4);
        chk("t6b accum_out", $signed(bus.accum_out), 240);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
